// File: rtl/arbiter10_bcd.sv
// Ten-way arbiter with round-robin / fixed-priority (9 highest) policy and BCD grant index.
// Optional forced release after HOLD_MAX cycles of tenure when LOCK_TIMEOUT_EN is defined.
module arbiter10_bcd #(
  parameter int HOLD_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        model_sel,
  input  logic [9:0]  req,
  output logic [9:0]  grant,
  output logic [3:0]  grant_id,
  output logic        grant_valid,
`ifdef LOCK_TIMEOUT_EN
  output logic        timeout,
`endif
  output logic        busy
);

  // state | meaning
  // IDLE  | no grant held; arbitrate when en=1 and req!=0
  // GRANT | one requester owns the resource until release/revoke
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_grant;
  logic [9:0]  w_grant_nxt;
  logic [3:0]  r_grant_id;
  logic [3:0]  w_grant_id_nxt;
  logic        r_grant_valid;
  logic        w_grant_valid_nxt;
  logic [3:0]  r_last_id;
  logic [3:0]  w_last_id_nxt;
  logic [3:0]  w_winner;
  logic        w_held;

`ifdef LOCK_TIMEOUT_EN
  logic [7:0]  r_hold_cnt;
  logic [7:0]  w_hold_cnt_nxt;
  logic        r_timeout;
  logic        w_timeout_nxt;
  logic        w_expired;
`endif

  // Winner: fixed priority keeps the highest set bit; round-robin keeps the
  // first set bit scanning upward from last_id+1 (loop runs backwards so the
  // nearest candidate is the final assignment).
  always_comb begin
    logic [4:0] w_sum;
    w_winner = 4'd0;
    w_sum    = 5'd0;
    if (model_sel) begin
      for (int i = 0; i < 10; i++) begin
        if (req[i]) w_winner = 4'(i);
      end
    end else begin
      for (int k = 9; k >= 0; k--) begin
        w_sum = {1'b0, r_last_id} + 5'(k) + 5'd1;
        if (w_sum >= 5'd10) w_sum = w_sum - 5'd10;
        if (req[w_sum[3:0]]) w_winner = w_sum[3:0];
      end
    end
  end

  assign w_held = en && req[r_grant_id];

`ifdef LOCK_TIMEOUT_EN
  assign w_expired = (r_hold_cnt == 8'(HOLD_MAX - 1));
`endif

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_grant_id_nxt    = r_grant_id;
    w_grant_valid_nxt = r_grant_valid;
    w_last_id_nxt     = r_last_id;
`ifdef LOCK_TIMEOUT_EN
    w_hold_cnt_nxt    = r_hold_cnt + 8'd1;
    w_timeout_nxt     = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (en && (req != 10'd0)) begin
          w_state_nxt       = GRANT;
          w_grant_nxt       = 10'd1 << w_winner;
          w_grant_id_nxt    = w_winner;
          w_grant_valid_nxt = 1'b1;
          w_last_id_nxt     = w_winner;
`ifdef LOCK_TIMEOUT_EN
          w_hold_cnt_nxt    = 8'd0;
`endif
        end else begin
          w_grant_nxt       = 10'd0;
          w_grant_id_nxt    = 4'd0;
          w_grant_valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (!w_held) begin
          w_state_nxt       = IDLE;
          w_grant_nxt       = 10'd0;
          w_grant_id_nxt    = 4'd0;
          w_grant_valid_nxt = 1'b0;
        end
`ifdef LOCK_TIMEOUT_EN
        else if (w_expired) begin
          // Forced release only when the grant would otherwise have been held.
          w_state_nxt       = IDLE;
          w_grant_nxt       = 10'd0;
          w_grant_id_nxt    = 4'd0;
          w_grant_valid_nxt = 1'b0;
          w_timeout_nxt     = 1'b1;
        end
`endif
      end
      default: begin
        w_state_nxt       = IDLE;
        w_grant_nxt       = 10'd0;
        w_grant_id_nxt    = 4'd0;
        w_grant_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_grant       <= 10'd0;
      r_grant_id    <= 4'd0;
      r_grant_valid <= 1'b0;
      r_last_id     <= 4'd9;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_last_id     <= w_last_id_nxt;
    end
  end

`ifdef LOCK_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_hold_cnt <= w_hold_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign timeout = r_timeout;
`endif

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_valid = r_grant_valid;
  assign busy        = (r_state == GRANT);

endmodule

// File: tb/tb_arbiter10_bcd.sv
// Directed self-checking bench for arbiter10_bcd; covers LOCK_TIMEOUT_EN when defined.
module tb_arbiter10_bcd;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       model_sel;
  logic [9:0] req;
  logic [9:0] grant;
  logic [3:0] grant_id;
  logic       grant_valid;
  logic       busy;
`ifdef LOCK_TIMEOUT_EN
  logic       timeout;
`endif

  int checks = 0;
  int errors = 0;

  arbiter10_bcd #(.HOLD_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .model_sel   (model_sel),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
`ifdef LOCK_TIMEOUT_EN
    .timeout     (timeout),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_id"},    32'(grant_id), 32'h0);
    chk({tag, "_valid"}, 32'(grant_valid), 32'h0);
    chk({tag, "_busy"},  32'(busy), 32'h0);
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] id);
    chk({tag, "_grant"}, 32'(grant), 32'(10'd1 << id));
    chk({tag, "_id"},    32'(grant_id), 32'(id));
    chk({tag, "_valid"}, 32'(grant_valid), 32'h1);
    chk({tag, "_busy"},  32'(busy), 32'h1);
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b1;
    #3 rst = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    rst = 1'b1; en = 1'b0; model_sel = 1'b0; req = 10'd0;
    #1;
    chk_idle("reset");
    step(); step();
    rst = 1'b0;
    chk_idle("post_reset");

    // single request
    en = 1'b1; req = 10'h008;
    step();
    chk_grant("single", 4'd3);
    req = 10'h000;
    step();
    chk_idle("single_rel");

    // fixed priority, no pre-emption, one idle cycle between grants
    model_sel = 1'b1; req = 10'h201;
    step();
    chk_grant("fp_first", 4'd9);
    step();
    chk_grant("fp_hold", 4'd9);
    req = 10'h001;
    step();
    chk_idle("fp_rel");
    step();
    chk_grant("fp_second", 4'd0);
    model_sel = 1'b0;
    step();
    chk_grant("fp_modesel_ignored", 4'd0);
    req = 10'h000;
    step();
    chk_idle("fp_done");

    // round-robin wrap from reset
    reset_pulse();
    model_sel = 1'b0; req = 10'h3FF;
    for (int n = 0; n < 11; n++) begin
      e = 4'(n % 10);
      step();
      chk_grant("rr_grant", e);
      step();
      chk_grant("rr_hold", e);
      req = 10'h3FF & ~(10'd1 << e);
      step();
      chk_idle("rr_rel");
      req = 10'h3FF;
    end
    req = 10'h000;
    step();
    chk_idle("rr_done");

    // revoke via en
    req = 10'h020;
    step();
    chk_grant("rv_grant", 4'd5);
    en = 1'b0;
    step();
    chk_idle("rv_revoked");
    en = 1'b1;
    step();
    chk_grant("rv_regrant", 4'd5);
    req = 10'h000;
    step();
    chk_idle("rv_done");

    // async reset mid-grant; last_id returns to 9
    req = 10'h080;
    step();
    chk_grant("ar_grant", 4'd7);
    #3 rst = 1'b1;
    #1;
    chk_idle("ar_cleared");
    #1 rst = 1'b0;
    req = 10'h3FF;
    step();
    chk_grant("ar_rr_start", 4'd0);
    req = 10'h000;
    step();
    chk_idle("ar_done");

`ifdef LOCK_TIMEOUT_EN
    reset_pulse();
    req = 10'h004;
    step();
    chk_grant("to_c0", 4'd2);
    chk("to_pulse0", 32'(timeout), 32'h0);
    for (int c = 1; c < 4; c++) begin
      step();
      chk_grant("to_hold", 4'd2);
      chk("to_nopulse", 32'(timeout), 32'h0);
    end
    step();
    chk_idle("to_forced");
    chk("to_pulse", 32'(timeout), 32'h1);
    step();
    chk_grant("to_regrant", 4'd2);
    chk("to_pulse_end", 32'(timeout), 32'h0);
    req = 10'h000;
    step();
    chk_idle("to_done");
    chk("to_norm_rel", 32'(timeout), 32'h0);
`else
    req = 10'h004;
    step();
    chk_grant("hold_start", 4'd2);
    for (int c = 0; c < 20; c++) step();
    chk_grant("hold_long", 4'd2);
    req = 10'h000;
    step();
    chk_idle("hold_done");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbiter10_bcd.md
Name: arbiter10_bcd

Overview:
- Sequential arbiter that shares one downstream resource among 10 requesters, indexed 0..9.
- Grants the resource under either round-robin or fixed-priority policy, selected by model_sel. In fixed-priority mode, index 9 has the highest priority, matching the 10-line priority encoding convention.
- Presents the winner as a one-hot grant and a BCD index (0..9) for the datapath mux.

Parameters:
- HOLD_MAX, 16, maximum grant tenure in cycles. Used only when LOCK_TIMEOUT_EN is defined. Legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  arbiter enable. 0 = no new grants, and any current grant is revoked.
- model_sel  input  1  policy select. 0 = round-robin, 1 = fixed priority (9 highest).
- req  input  10  request vector. req[i]=1 means requester i wants the resource; it stays high for the whole tenure.
- grant  output  10  one-hot grant, registered.
- grant_id  output  4  BCD index of the granted requester, 0..9. Equals 0 when grant_valid=0.
- grant_valid  output  1  1 while a grant is held.
- busy  output  1  1 when the state is not IDLE.
- timeout  output  1  one-cycle pulse on a forced release. Present only with LOCK_TIMEOUT_EN.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, grant=0, grant_id=0, grant_valid=0, busy=0, timeout=0.
  - last_id=9, so the first round-robin search starts at index 0.
- States: IDLE, GRANT.
- IDLE:
  - If en=1 and req!=0 at an edge, compute the winner from the req sampled at that edge.
  - At that same edge: grant=onehot(winner), grant_id=winner, grant_valid=1, busy=1, last_id=winner, state=GRANT.
  - Latency: grant is visible one cycle after req is first sampled high.
  - If en=0 or req=0, stay in IDLE with all outputs 0.
- Winner selection:
  - model_sel=1: highest set index wins.
  - model_sel=0: search upward from (last_id+1) mod 10, wrapping 9->0. The first set bit wins.
  - model_sel is sampled only at arbitration edges.
- GRANT:
  - Hold grant/grant_id unchanged while en=1 and req[grant_id]=1.
  - Release: at an edge where req[grant_id]=0, clear grant, grant_id and grant_valid, and go to IDLE.
  - Revoke: at an edge where en=0, same as release; last_id is kept.
  - After any release or revoke, at least one cycle is spent in IDLE (busy=0) before the next grant. There are no back-to-back grants.
  - Requests from other indices during GRANT are ignored; no pre-emption, even by a higher priority in mode 1.
  - Changing model_sel during GRANT has no effect on the current grant.
- Simultaneous events:
  - Release and new requests at the same edge: release wins. The new requests are arbitrated at the following edge from IDLE.
- Invariants:
  - grant is zero or one-hot.
  - grant_id < 10 always.
  - grant[grant_id]=1 whenever grant_valid=1.
- Reset mid-grant: outputs clear immediately (asynchronous), and last_id returns to 9.

Optional Feature:
- Macro: LOCK_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each cycle in GRANT.
  - When the count reaches HOLD_MAX-1 and the grant is still held, the next edge forces a release to IDLE and timeout=1 for exactly that one cycle. Tenure is therefore exactly HOLD_MAX cycles.
  - A normal release or revoke at the same edge takes precedence, and timeout stays 0.
  - A requester still holding req after a timeout re-enters arbitration normally. In round-robin mode, other requesters are served first.
- Undefined: no counter and no timeout port; a grant is held indefinitely.

Test Plan:
- Reset then single request: req=10'h008 -> one cycle later grant=10'h008, grant_id=3, grant_valid=1. Drop req -> next cycle all outputs 0, busy=0.
- Fixed priority: model_sel=1, req=10'h201 -> grant_id=9. Keep bit 9 held while bit 0 stays set -> no pre-emption. Drop bit 9 -> one IDLE cycle, then grant_id=0.
- Round-robin wrap: model_sel=0, req held at 10'h3FF, each requester releasing after 2 cycles -> grant_id sequence 0,1,...,9,0, with one idle cycle between grants.
- Revoke: grant on id 5, then en=0 mid-tenure -> next edge grant=0, grant_valid=0. Re-enable with req=10'h020 -> grant_id=5 again after one cycle.
- Async reset mid-grant: assert rst between clock edges while grant_id=7 -> outputs clear without waiting for an edge. After release, req=10'h3FF in mode 0 -> grant_id=0.
- LOCK_TIMEOUT_EN, HOLD_MAX=4: req=10'h004 held steady -> grant for exactly 4 cycles, then timeout pulses once and grant=0 for 1 cycle, then re-grant id 2.
